// File: rtl/placar_bcd_hex.sv
// Score display driver: converts two 10-bit binary scores to BCD with a shared
// sequential double-dabble datapath and drives six seven-segment HEX displays.
module placar_bcd_hex #(
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] placarAtual,
  input  logic [9:0] placarMaximo,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       busy,
  output logic       upd
);

  typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, UPDATE} state_t;

  localparam logic [6:0] SEG_ZERO  = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
  localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [6:0] SEG_LZ    = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  state_t      state;
  logic [9:0]  snap_a;
  logic [9:0]  snap_m;
  logic [21:0] work;      // {bcd[11:0], binary[9:0]} shift register
  logic [11:0] bcd_a;
  logic [3:0]  cnt;
  logic [21:0] work_next;
  logic [20:0] segs_a;
  logic [20:0] segs_m;

  function automatic logic [9:0] sat999(input logic [9:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  function automatic logic [21:0] dabble(input logic [21:0] w);
    logic [21:0] t;
    t = w;
    for (int i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    if (blank) s = 7'b1111111;
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  // Returns {hundreds, tens, units} segment patterns with leading-zero blanking.
  function automatic logic [20:0] bcd_to_segs(input logic [11:0] b);
    logic blank_h;
    logic blank_t;
    blank_h = BLANK_LZ && (b[11:8] == 4'd0);
    blank_t = blank_h && (b[7:4] == 4'd0);
    return {seg7(b[11:8], blank_h), seg7(b[7:4], blank_t), seg7(b[3:0], 1'b0)};
  endfunction

  assign work_next = dabble(work);
  assign segs_a    = bcd_to_segs(bcd_a);
  assign segs_m    = bcd_to_segs(work[21:10]);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      snap_a <= '0;
      snap_m <= '0;
      work   <= '0;
      bcd_a  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      upd    <= 1'b0;
      HEX0   <= SEG_ZERO;
      HEX1   <= SEG_LZ;
      HEX2   <= SEG_LZ;
      HEX3   <= SEG_ZERO;
      HEX4   <= SEG_LZ;
      HEX5   <= SEG_LZ;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if ({placarAtual, placarMaximo} != {snap_a, snap_m}) begin
            snap_a <= placarAtual;
            snap_m <= placarMaximo;
            work   <= {12'd0, sat999(placarAtual)};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CONV_A;
          end
        end
        CONV_A: begin
          if (cnt == 4'd9) begin
            bcd_a <= work_next[21:10];
            work  <= {12'd0, sat999(snap_m)};
            cnt   <= '0;
            state <= CONV_B;
          end else begin
            work <= work_next;
            cnt  <= cnt + 4'd1;
          end
        end
        CONV_B: begin
          work <= work_next;
          if (cnt == 4'd9) begin
            cnt   <= '0;
            state <= UPDATE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        UPDATE: begin
          {HEX2, HEX1, HEX0} <= segs_a;
          {HEX5, HEX4, HEX3} <= segs_m;
          upd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_placar_bcd_hex.sv
// Directed bench for placar_bcd_hex with default parameters (blanking on,
// active-low segments); expected segment patterns are hand-entered constants.
module tb_placar_bcd_hex;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic [9:0] placarAtual  = '0;
  logic [9:0] placarMaximo = '0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       busy, upd;

  int n_cmp = 0;
  int n_bad = 0;

  placar_bcd_hex dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .placarAtual (placarAtual),
    .placarMaximo(placarMaximo),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5),
    .busy        (busy),
    .upd         (upd)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                         input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, ".HEX5"}, HEX5, e5);
    chk({tag, ".HEX4"}, HEX4, e4);
    chk({tag, ".HEX3"}, HEX3, e3);
    chk({tag, ".HEX2"}, HEX2, e2);
    chk({tag, ".HEX1"}, HEX1, e1);
    chk({tag, ".HEX0"}, HEX0, e0);
  endtask

  // Called at posedge+1; lat is the edge index (sampling edge = 1) where upd is first seen.
  task automatic run_conv(input logic [9:0] a, input logic [9:0] m,
                          output int lat, output int nbusy, output int nupd);
    placarAtual  = a;
    placarMaximo = m;
    lat = -1; nbusy = 0; nupd = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLOCK_50); #1;
      if (busy) nbusy++;
      if (upd) begin
        nupd++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  initial begin
    int lat, nbusy, nupd, first, second;
    logic [6:0] hex0_first, hex1_first, hex0_second;

    // Reset with 0/0 held
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_hex("rst_hold", SB, SB, S0, SB, SB, S0);
    chk("rst_busy", busy, 0);
    chk("rst_upd", upd, 0);
    reset = 1'b1;
    nbusy = 0; nupd = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLOCK_50); #1;
      if (busy) nbusy++;
      if (upd) nupd++;
    end
    chk("idle_busy_cycles", nbusy, 0);
    chk("idle_upd_pulses", nupd, 0);
    chk_hex("idle_hex", SB, SB, S0, SB, SB, S0);

    // 123 / 987
    run_conv(10'd123, 10'd987, lat, nbusy, nupd);
    chk("c123_latency", lat, 22);
    chk("c123_busy_cycles", nbusy, 21);
    chk("c123_upd_pulses", nupd, 1);
    chk_hex("c123", S9, S8, S7, S1, S2, S3);

    // 7 / 40 leading-zero blanking
    run_conv(10'd7, 10'd40, lat, nbusy, nupd);
    chk("c7_latency", lat, 22);
    chk_hex("c7_40", SB, S4, S0, SB, SB, S7);

    // Saturation of out-of-range scores
    run_conv(10'd1023, 10'd1000, lat, nbusy, nupd);
    chk("csat_upd_pulses", nupd, 1);
    chk_hex("csat", S9, S9, S9, S9, S9, S9);

    // Change 5 -> 6 during CONV_A
    placarAtual  = 10'd5;
    placarMaximo = 10'd0;
    first = -1; second = -1;
    hex0_first = '0; hex1_first = '0; hex0_second = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CLOCK_50); #1;
      if (i == 4) placarAtual = 10'd6;
      if (upd) begin
        if (first < 0) begin
          first = i; hex0_first = HEX0; hex1_first = HEX1;
        end else if (second < 0) begin
          second = i; hex0_second = HEX0;
        end
      end
    end
    chk("mid_first_lat", first, 22);
    chk("mid_first_hex0", hex0_first, S5);
    chk("mid_first_hex1", hex1_first, SB);
    chk("mid_second_lat", second - first, 22);
    chk("mid_second_hex0", hex0_second, S6);
    chk("mid_hex3", HEX3, S0);

    // Reset during CONV_B of 456 / 789
    placarAtual  = 10'd456;
    placarMaximo = 10'd789;
    nupd = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge CLOCK_50); #1;
      if (upd) nupd++;
    end
    chk("abort_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk_hex("abort_async", SB, SB, S0, SB, SB, S0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK_50); #1;
      if (upd) nupd++;
    end
    chk("abort_upd_pulses", nupd, 0);
    chk_hex("abort_held", SB, SB, S0, SB, SB, S0);
    reset = 1'b1;
    run_conv(10'd456, 10'd789, lat, nbusy, nupd);
    chk("restart_latency", lat, 22);
    chk("restart_upd_pulses", nupd, 1);
    chk_hex("restart", S7, S8, S9, S4, S5, S6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
